// File: rtl/change_log_pkg.sv
// Shared constants and types for the word change logger.
// The entry typedef describes the default-width {time, value} layout.
package change_log_pkg;

  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam int unsigned DEFAULT_TS_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH    = 8;

  localparam logic [7:0] DROP_SAT = 8'd255;

  typedef struct packed {
    logic [DEFAULT_TS_WIDTH-1:0] ts;
    logic [DEFAULT_WIDTH-1:0]    value;
  } log_entry_t;

  // Saturating increment used by the drop counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == DROP_SAT) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO on registered storage with explicit occupancy counter.
// Push while full is ignored unless a pop frees the slot at the same edge.
module sync_fifo #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);

  // Clear wins over both sides; a pop on a full FIFO makes room for the push.
  assign do_pop  = pop_i & ~empty_o & ~clr_i;
  assign do_push = push_i & (~full_o | do_pop) & ~clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Stale storage is masked so an empty FIFO always presents zero.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/word_change_logger.sv
// Samples a word every clock and logs {timestamp, value} only when the value changes.
// Entries drain over valid/ready; drops on a full log are counted and flagged.
module word_change_logger
  import change_log_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned TS_WIDTH = DEFAULT_TS_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_value,
  output logic [TS_WIDTH-1:0]      out_time,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  output logic [$clog2(DEPTH):0]   level
);

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [WIDTH-1:0]    value;
  } entry_t;

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic                first_q, first_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic   log_req, push, pop, drop;
  logic   fifo_full, fifo_empty;
  entry_t wr_entry, rd_entry;

  // The first sample after reset or clear is always logged.
  assign log_req  = first_q | (data_in != prev_q);
  assign push     = log_req & ~clear;
  assign pop      = out_valid & out_ready;
  assign drop     = push & fifo_full & ~pop;
  assign wr_entry = '{ts: ts_q, value: data_in};

  always_comb begin
    ts_d       = ts_q + TS_WIDTH'(1);
    prev_d     = data_in;
    first_d    = 1'b0;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      ts_d       = '0;
      first_d    = 1'b1;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q       <= '0;
      prev_q     <= '0;
      first_q    <= 1'b1;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .Width ($bits(entry_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clr_i   (clear),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign out_valid  = ~fifo_empty;
  assign out_value  = rd_entry.value;
  assign out_time   = rd_entry.ts;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_word_change_logger.sv
// Directed and randomized checks of word_change_logger against a queue-based log model.
module tb_word_change_logger;

  localparam int unsigned W   = 8;
  localparam int unsigned TSW = 16;
  localparam int unsigned D   = 8;
  localparam int unsigned LW  = $clog2(D) + 1;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           clear;
  logic [W-1:0]   data_in;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_value;
  logic [TSW-1:0] out_time;
  logic           overflow;
  logic [7:0]     drop_count;
  logic [LW-1:0]  level;

  always #5 clock = ~clock;

  word_change_logger #(
    .WIDTH    (W),
    .TS_WIDTH (TSW),
    .DEPTH    (D)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .out_time   (out_time),
    .overflow   (overflow),
    .drop_count (drop_count),
    .level      (level)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference log: pending entries as two parallel queues, plus elapsed-edge count.
  logic [W-1:0]   mv_q[$];
  logic [TSW-1:0] mt_q[$];
  int             m_ts;
  logic [W-1:0]   m_prev;
  bit             m_first;
  bit             m_ovf;
  int             m_drops;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mv_q.delete();
    mt_q.delete();
    m_ts    = 0;
    m_prev  = '0;
    m_first = 1'b1;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] d, input bit c, input bit r);
    bit changed;
    if (c) begin
      model_reset();
      return;
    end
    changed = m_first || (d != m_prev);
    if (r && mv_q.size() > 0) begin
      void'(mv_q.pop_front());
      void'(mt_q.pop_front());
    end
    if (changed) begin
      if (mv_q.size() < D) begin
        mv_q.push_back(d);
        mt_q.push_back(TSW'(m_ts));
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    m_ts    = (m_ts + 1) % (1 << TSW);
    m_prev  = d;
    m_first = 1'b0;
  endtask

  task automatic check_all(input string ctx);
    logic [W-1:0]   ev;
    logic [TSW-1:0] et;
    ev = '0;
    et = '0;
    if (mv_q.size() > 0) begin
      ev = mv_q[0];
      et = mt_q[0];
    end
    chk({ctx, ".valid"}, 32'(out_valid), 32'(mv_q.size() > 0));
    chk({ctx, ".value"}, 32'(out_value), 32'(ev));
    chk({ctx, ".time"},  32'(out_time),  32'(et));
    chk({ctx, ".level"}, 32'(level),     32'(mv_q.size()));
    chk({ctx, ".ovf"},   32'(overflow),  32'(m_ovf));
    chk({ctx, ".drops"}, 32'(drop_count), 32'(m_drops));
  endtask

  // Drive inputs (away from the edge), take one edge, then compare 1 time unit later.
  task automatic step(input string ctx, input logic [W-1:0] d, input bit c, input bit r);
    data_in   = d;
    clear     = c;
    out_ready = r;
    @(posedge clock);
    model_edge(d, c, r);
    #1;
    check_all(ctx);
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clock);
    #2;
    reset_n = 1'b1;

    // Two changes logged at t=0 and t=3, then drained in order.
    for (int i = 0; i < 3; i++) step("first", 8'd32, 1'b0, 1'b0);
    step("first", 8'd28, 1'b0, 1'b0);
    chk("first.t3", 32'(mt_q.size() == 2 && mt_q[1] == 16'd3), 32'd1);
    step("drain1", 8'd28, 1'b0, 1'b1);
    step("drain1", 8'd28, 1'b0, 1'b1);

    // Steady input: a single entry, nothing more.
    for (int i = 0; i < 41; i++) step("steady", 8'd74, 1'b0, 1'b1);

    // Ten back-to-back changes with no consumer: eight kept, two dropped.
    for (int i = 0; i < 10; i++) step("burst", W'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("drain2", 8'd109, 1'b0, 1'b1);

    // Full plus a simultaneous pop: the new change is accepted.
    for (int i = 0; i < 8; i++) step("fill", W'(120 + i), 1'b0, 1'b0);
    step("fullpop", 8'd128, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("part", 8'd128, 1'b0, 1'b1);

    // Clear with three queued entries; the repeated value is logged at t=0.
    step("clear", 8'd128, 1'b1, 1'b0);
    step("postclr", 8'd128, 1'b0, 1'b0);
    chk("postclr.t0", 32'(out_time), 32'd0);

    // Asynchronous reset mid-drain.
    step("prerst", 8'd1, 1'b0, 1'b0);
    step("prerst", 8'd2, 1'b0, 1'b0);
    step("prerst", 8'd3, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    step("postrst", 8'd3, 1'b0, 1'b0);

    // Random traffic over a small alphabet so repeats and full conditions both occur.
    for (int i = 0; i < 400; i++) begin
      step("rand", W'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
